aibnd_red_clksel_ctl: RTL and testbench

AIBND_RED_CLKSEL_CTL -- requirements
Module: aibnd_red_clksel_ctl

---
 rtl/aibnd_red_pkg.sv | 14 +
 rtl/aibnd_red_dncnt.sv | 30 +++
 rtl/aibnd_red_clksel_ctl.sv | 126 ++++++++++++
 tb/tb_aibnd_red_clksel_ctl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/aibnd_red_pkg.sv
// Shared types and default timing constants for the redundancy clock-select controller.
package aibnd_red_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  localparam int unsigned GATE_CYC_DEF   = 4;
  localparam int unsigned SETTLE_CYC_DEF = 8;
  localparam int unsigned CNT_W_DEF      = 4;

endpackage

// File: rtl/aibnd_red_dncnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module aibnd_red_dncnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_count = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/aibnd_red_clksel_ctl.sv
// Glitch-free select sequencer for the redundancy clock mux: gate output,
// switch select, let it settle, then ungate and acknowledge.
module aibnd_red_clksel_ctl
  import aibnd_red_pkg::*;
#(
  parameter int unsigned GATE_CYC   = GATE_CYC_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req_vld,
  input  logic req_sel,
  input  logic vccl_aibnd,
  input  logic vssl_aibnd,
  output logic s,
  output logic clk_en,
  output logic busy,
  output logic chg_ack
);

  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_s, r_clk_en, r_busy, r_ack, r_tgt;
  logic   w_s_nxt, w_clk_en_nxt, w_busy_nxt, w_ack_nxt, w_tgt_nxt;
  logic   w_load, w_dec, w_zero;
  logic [CNT_W-1:0] w_ld_val;
  logic [CNT_W-1:0] w_count;

  // Supply pins carry no logic.
  logic w_unused;
  assign w_unused = vccl_aibnd ^ vssl_aibnd ^ (|w_count);

  aibnd_red_dncnt #(
    .CNT_W(CNT_W)
  ) u_dncnt (
    .clk       (clk),
    .i_reset   (reset),
    .i_load    (w_load),
    .i_load_val(w_ld_val),
    .i_dec     (w_dec),
    .o_count   (w_count),
    .o_zero    (w_zero)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_s      <= 1'b0;
      r_clk_en <= 1'b1;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_tgt    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_s      <= w_s_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_busy   <= w_busy_nxt;
      r_ack    <= w_ack_nxt;
      r_tgt    <= w_tgt_nxt;
    end
  end

  // Next-state, next-output and counter control.
  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_clk_en_nxt = r_clk_en;
    w_busy_nxt   = r_busy;
    w_ack_nxt    = 1'b0;
    w_tgt_nxt    = r_tgt;
    w_load       = 1'b0;
    w_ld_val     = '0;
    w_dec        = 1'b0;
    unique case (r_state)
      IDLE: begin
        // The ack cycle is a dead cycle: requests are only sampled after it.
        if (req_vld && !r_ack) begin
          if (req_sel != r_s) begin
            w_state_nxt  = GATE;
            w_clk_en_nxt = 1'b0;
            w_busy_nxt   = 1'b1;
            w_tgt_nxt    = req_sel;
            w_load       = 1'b1;
            w_ld_val     = GATE_LD;
          end else begin
            w_ack_nxt = 1'b1;
          end
        end
      end
      GATE: begin
        if (w_zero) begin
          w_state_nxt = SETTLE;
          w_s_nxt     = r_tgt;
          w_load      = 1'b1;
          w_ld_val    = SETTLE_LD;
        end else begin
          w_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (w_zero) begin
          w_state_nxt  = IDLE;
          w_clk_en_nxt = 1'b1;
          w_busy_nxt   = 1'b0;
          w_ack_nxt    = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign s       = r_s;
  assign clk_en  = r_clk_en;
  assign busy    = r_busy;
  assign chg_ack = r_ack;

endmodule

// File: tb/tb_aibnd_red_clksel_ctl.sv
// Directed bench: three controller instances (default, 1/1, 16/16 timing).
module tb_aibnd_red_clksel_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, vld, sel;
  logic [2:0] s, en, busy, ack;
  logic       vcc = 1'b1;
  logic       vss = 1'b0;

  int checks   = 0;
  int failures = 0;

  aibnd_red_clksel_ctl u_dut0 (
    .clk(clk), .reset(rst[0]), .req_vld(vld[0]), .req_sel(sel[0]),
    .vccl_aibnd(vcc), .vssl_aibnd(vss),
    .s(s[0]), .clk_en(en[0]), .busy(busy[0]), .chg_ack(ack[0])
  );

  aibnd_red_clksel_ctl #(.GATE_CYC(1), .SETTLE_CYC(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req_vld(vld[1]), .req_sel(sel[1]),
    .vccl_aibnd(vcc), .vssl_aibnd(vss),
    .s(s[1]), .clk_en(en[1]), .busy(busy[1]), .chg_ack(ack[1])
  );

  aibnd_red_clksel_ctl #(.GATE_CYC(16), .SETTLE_CYC(16), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(rst[2]), .req_vld(vld[2]), .req_sel(sel[2]),
    .vccl_aibnd(vcc), .vssl_aibnd(vss),
    .s(s[2]), .clk_en(en[2]), .busy(busy[2]), .chg_ack(ack[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare all four outputs of instance d against {s, clk_en, busy, chg_ack}.
  task automatic chk4(input int d, input string tag, input int k, input logic [3:0] e);
    chk($sformatf("d%0d.%s.s@%0d", d, tag, k), s[d], e[3]);
    chk($sformatf("d%0d.%s.clk_en@%0d", d, tag, k), en[d], e[2]);
    chk($sformatf("d%0d.%s.busy@%0d", d, tag, k), busy[d], e[1]);
    chk($sformatf("d%0d.%s.chg_ack@%0d", d, tag, k), ack[d], e[0]);
  endtask

  // Expected {s, clk_en, busy, chg_ack} k cycles after the request edge.
  function automatic logic [3:0] expv(input int k, input int g, input int st,
                                      input logic s0, input logic tgt);
    logic es, ee, eb, ea;
    es = (k >= g + 1) ? tgt : s0;
    ee = (k >= g + st + 1) || (k <= 0);
    eb = (k >= 1) && (k <= g + st);
    ea = (k == g + st + 1);
    return {es, ee, eb, ea};
  endfunction

  // s must hold across any non-reset edge where clk_en was high.
  logic [2:0] pre_s, pre_en, pre_rst;
  always @(posedge clk) begin
    pre_s   = s;
    pre_en  = en;
    pre_rst = rst;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pre_en[i] === 1'b1 && pre_rst[i] === 1'b0) begin
        checks++;
        assert (s[i] === pre_s[i]) else begin
          failures++;
          $error("FAIL d%0d.s_stable observed=%b expected=%b", i, s[i], pre_s[i]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 3'b111; vld = '0; sel = '0;
    step(); step(); step();
    for (int d = 0; d < 3; d++) chk4(d, "reset", 0, 4'b0100);
    rst[0] = 1'b0;
    step();

    // Request matching current select: ack only.
    vld[0] = 1'b1; sel[0] = 1'b0;
    step(); chk4(0, "same", 1, 4'b0101);
    vld[0] = 1'b0;
    step(); chk4(0, "same", 2, 4'b0100);

    // Switch to 1, target flips to 0 mid-GATE; held request starts a second sequence.
    vld[0] = 1'b1; sel[0] = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      step();
      if (k <= 14) chk4(0, "seq", k, expv(k, 4, 8, 1'b0, 1'b1));
      else         chk4(0, "seq", k, expv(k - 14, 4, 8, 1'b1, 1'b0));
      if (k == 2) sel[0] = 1'b0;
    end
    vld[0] = 1'b0;
    step(); chk4(0, "seq", 28, 4'b0100);

    // Reset in SETTLE aborts without ack.
    vld[0] = 1'b1; sel[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(); chk4(0, "abort", k, expv(k, 4, 8, 1'b0, 1'b1));
    end
    rst[0] = 1'b1; vld[0] = 1'b0;
    step(); chk4(0, "abort", 8, 4'b0100);
    rst[0] = 1'b0;
    for (int k = 9; k <= 13; k++) begin
      step(); chk4(0, "abort", k, 4'b0100);
    end

    // Request pending across reset release.
    rst[0] = 1'b1; vld[0] = 1'b1; sel[0] = 1'b1;
    step(); step(); chk4(0, "pend", 0, 4'b0100);
    rst[0] = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step(); chk4(0, "pend", k, expv(k, 4, 8, 1'b0, 1'b1));
    end
    vld[0] = 1'b0;
    step(); chk4(0, "pend", 14, 4'b1100);

    // Minimum timing.
    rst[1] = 1'b0;
    step();
    vld[1] = 1'b1; sel[1] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(); chk4(1, "min", k, expv(k, 1, 1, 1'b0, 1'b1));
    end
    vld[1] = 1'b0;
    step(); chk4(1, "min", 4, 4'b1100);

    // Maximum timing for a 4-bit counter.
    rst[2] = 1'b0;
    step();
    vld[2] = 1'b1; sel[2] = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      step(); chk4(2, "max", k, expv(k, 16, 16, 1'b0, 1'b1));
    end
    vld[2] = 1'b0;
    step(); chk4(2, "max", 34, 4'b1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
